// File: rtl/pixel_stream_proc_if.sv
// Beat-level stream bundle for pixel_stream_proc: input beat handshake and registered output beat.
// master = stream source/sink side (testbench or upstream), slave = the processing block.
interface pixel_stream_proc_if #(
  parameter int PPC = 2
);
  logic                 in_valid;
  logic                 in_ready;
  logic [24*PPC-1:0]    in_data;
  logic                 out_valid;
  logic [24*PPC-1:0]    out_data;

  modport master (
    output in_valid, in_data,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pixel_stream_proc.sv
// Frame-sequenced pixel processor: VSYNC start-up wait, per-line blanking, then PPC-wide beats
// through a pass / brightness / invert / threshold datapath with one cycle of latency.
module pixel_stream_proc #(
  parameter int WIDTH          = 768,
  parameter int HEIGHT         = 512,
  parameter int PPC            = 2,
  parameter int START_UP_DELAY = 100,
  parameter int HSYNC_DELAY    = 160
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [7:0]         value,
  input  logic               sign,
  input  logic [7:0]         threshold,
  pixel_stream_proc_if.slave bus,
  output logic               VSYNC,
  output logic               HSYNC,
  output logic               ctrl_done
);

  localparam int VW = (START_UP_DELAY > 0) ? $clog2(START_UP_DELAY + 1) : 1;
  localparam int HW = (HSYNC_DELAY > 0) ? $clog2(HSYNC_DELAY + 1) : 1;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_HSYNC, S_DATA, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [VW-1:0]     vcnt_q, vcnt_d;
  logic [HW-1:0]     hcnt_q, hcnt_d;
  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [1:0]        mode_q;
  logic              sign_q;
  logic [7:0]        value_q, thr_q;
  logic              out_valid_q;
  logic [24*PPC-1:0] out_data_q, proc_data;
  logic              ready, accept, line_end, last_row;

  assign accept   = bus.in_valid & ready;
  assign line_end = accept && (col_q == CW'(WIDTH - PPC));
  assign last_row = (row_q == RW'(HEIGHT - 1));

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_VSYNC;
      S_VSYNC: if (vcnt_q == VW'(START_UP_DELAY)) state_d = S_HSYNC;
      S_HSYNC: if (hcnt_q == HW'(HSYNC_DELAY)) state_d = S_DATA;
      S_DATA:  if (line_end) state_d = last_row ? S_DONE : S_HSYNC;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ready     = (state_q == S_DATA);
    VSYNC     = (state_q == S_VSYNC);
    ctrl_done = (state_q == S_DONE);
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign HSYNC         = out_valid_q;

  // Each phase counter runs only while its own state is current and is zero otherwise.
  always_comb begin
    vcnt_d = '0;
    hcnt_d = '0;
    col_d  = col_q;
    row_d  = row_q;
    if (state_q == S_VSYNC && vcnt_q != VW'(START_UP_DELAY)) vcnt_d = vcnt_q + 1'b1;
    if (state_q == S_HSYNC && hcnt_q != HW'(HSYNC_DELAY))    hcnt_d = hcnt_q + 1'b1;
    if (state_q != S_DATA)  col_d = '0;
    else if (accept)        col_d = line_end ? '0 : col_q + CW'(PPC);
    if (line_end)           row_d = row_q + 1'b1;
    else if (state_q == S_DONE || state_q == S_IDLE) row_d = '0;
  end

  function automatic logic [23:0] procPixel(input logic [23:0] pix, input logic [1:0] md,
                                            input logic sg, input logic [7:0] val,
                                            input logic [7:0] thr);
    logic [9:0]  sum, avg;
    logic [8:0]  s;
    logic [7:0]  c;
    logic [23:0] res;
    sum = {2'b00, pix[23:16]} + {2'b00, pix[15:8]} + {2'b00, pix[7:0]};
    avg = sum / 10'd3;
    res = pix;
    case (md)
      2'd1: begin
        for (int i = 0; i < 3; i++) begin
          c = pix[8*i +: 8];
          s = {1'b0, c} + {1'b0, val};
          if (sg) res[8*i +: 8] = s[8] ? 8'hFF : s[7:0];
          else    res[8*i +: 8] = (c > val) ? (c - val) : 8'h00;
        end
      end
      2'd2:    res = {3{8'hFF - avg[7:0]}};
      2'd3:    res = (avg > {2'b00, thr}) ? 24'hFFFFFF : 24'h000000;
      default: res = pix;
    endcase
    return res;
  endfunction

  always_comb begin
    proc_data = '0;
    for (int k = 0; k < PPC; k++)
      proc_data[24*k +: 24] = procPixel(bus.in_data[24*k +: 24], mode_q, sign_q, value_q, thr_q);
  end

  // Operands are captured once per frame on the IDLE->VSYNC edge; later input changes are ignored.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      vcnt_q      <= '0;
      hcnt_q      <= '0;
      col_q       <= '0;
      row_q       <= '0;
      mode_q      <= '0;
      sign_q      <= 1'b0;
      value_q     <= '0;
      thr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      vcnt_q      <= vcnt_d;
      hcnt_q      <= hcnt_d;
      col_q       <= col_d;
      row_q       <= row_d;
      out_valid_q <= accept;
      if (accept) out_data_q <= proc_data;
      if (state_q == S_IDLE && start) begin
        mode_q  <= mode;
        sign_q  <= sign;
        value_q <= value;
        thr_q   <= threshold;
      end
    end
  end

endmodule
